// File: rtl/adc_spi_responder.sv
// SPI responder emulating an 8-channel 12-bit ADC: 16-bit frames, 4 zero bits then the sample, MSB first.
// Define ADC_RESP_TESTPAT_EN to replace the sample with {cur_chan, frame_cnt} for bring-up.
module adc_spi_responder (
  input  logic        clk,
  input  logic        reset,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        din,
  output logic        dout,
  output logic        dout_oe,
  input  logic [95:0] chan_data,
  output logic [2:0]  cur_chan,
  output logic        frame_done,
  output logic        frame_err
);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t      state_q, state_d;
  // [1:0] are the synchroniser stages, [2] holds the previous synchronised value for edge detection
  logic [2:0]  sclk_q, cs_q;
  logic [1:0]  din_q;
  logic [15:0] shreg_q, shreg_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [2:0]  addr_q, addr_d;
  logic [2:0]  cur_chan_q, cur_chan_d;
  logic        dout_q, dout_d;
  logic        oe_q, oe_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [11:0] payload;
  logic        sclk_rise, sclk_fall, cs_rise, cs_fall;

`ifdef ADC_RESP_TESTPAT_EN
  logic [8:0]  frame_cnt_q, frame_cnt_d;
  logic        unused_chan;

  assign unused_chan = ^chan_data;
  assign payload     = {cur_chan_q, frame_cnt_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) frame_cnt_q <= '0;
    else       frame_cnt_q <= frame_cnt_d;
  end

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (state_q == HOLD && cs_rise) frame_cnt_d = frame_cnt_q + 9'd1;
  end
`else
  assign payload = chan_data[32'(cur_chan_q) * 12 +: 12];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_q <= 3'b111;
      cs_q   <= 3'b111;
      din_q  <= 2'b00;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk};
      cs_q   <= {cs_q[1:0], cs_n};
      din_q  <= {din_q[0], din};
    end
  end

  assign sclk_rise =  sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] &  sclk_q[2];
  assign cs_rise   =  cs_q[1]   & ~cs_q[2];
  assign cs_fall   = ~cs_q[1]   &  cs_q[2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      addr_q     <= '0;
      cur_chan_q <= '0;
      dout_q     <= 1'b0;
      oe_q       <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      addr_q     <= addr_d;
      cur_chan_q <= cur_chan_d;
      dout_q     <= dout_d;
      oe_q       <= oe_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    addr_d     = addr_q;
    cur_chan_d = cur_chan_q;
    oe_d       = oe_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        oe_d = 1'b0;
        if (cs_fall) begin
          state_d   = SHIFT;
          shreg_d   = {4'b0000, payload};
          bit_cnt_d = '0;
          addr_d    = '0;
          oe_d      = 1'b1;
        end
      end
      SHIFT: begin
        // cs_n rise wins over any sclk edge seen in the same cycle
        if (cs_rise) begin
          state_d = IDLE;
          err_d   = 1'b1;
          oe_d    = 1'b0;
        end else if (sclk_rise) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          case (bit_cnt_q)
            4'd2:    addr_d[2] = din_q[1];
            4'd3:    addr_d[1] = din_q[1];
            4'd4:    addr_d[0] = din_q[1];
            default: ;
          endcase
          if (bit_cnt_q == 4'd15) state_d = HOLD;
        end else if (sclk_fall && bit_cnt_q != 4'd0) begin
          // the leading fall (before any rise) must not consume the first bit
          shreg_d = {shreg_q[14:0], 1'b0};
        end
      end
      HOLD: begin
        if (cs_rise) begin
          state_d    = IDLE;
          cur_chan_d = addr_q;
          done_d     = 1'b1;
          oe_d       = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    dout_d = (state_d == SHIFT) ? shreg_d[15] : 1'b0;
  end

  assign dout       = dout_q;
  assign dout_oe    = oe_q;
  assign cur_chan   = cur_chan_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed + randomized frames against a frame-level model of the ADC responder.
module tb_adc_spi_responder;
  logic        clk = 1'b0;
  logic        reset, sclk, cs_n, din;
  logic        dout, dout_oe, frame_done, frame_err;
  logic [95:0] chan_data;
  logic [2:0]  cur_chan;

  int n_assert = 0;
  int n_fail   = 0;
  int n_done   = 0;
  int n_err    = 0;

  logic [11:0] mem [8];
  logic [2:0]  cur_m  = 3'd0;
  logic [8:0]  fcnt_m = 9'd0;

  always #5 clk = ~clk;

  adc_spi_responder dut (
    .clk        (clk),
    .reset      (reset),
    .sclk       (sclk),
    .cs_n       (cs_n),
    .din        (din),
    .dout       (dout),
    .dout_oe    (dout_oe),
    .chan_data  (chan_data),
    .cur_chan   (cur_chan),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  // counts clk cycles with each pulse high, so a stretched pulse shows up as >1
  always @(negedge clk) begin
    if (frame_done === 1'b1) n_done++;
    if (frame_err === 1'b1)  n_err++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_mem();
    for (int k = 0; k < 8; k++) chan_data[12*k +: 12] = mem[k];
  endtask

  task automatic frame(input logic [2:0] addr, input int nrise, input bit scramble);
    logic [15:0] got, exp, dword, mask;
    logic [11:0] pl;
    int d0, e0, extra_bad;
`ifdef ADC_RESP_TESTPAT_EN
    pl = {cur_m, fcnt_m};
`else
    pl = mem[cur_m];
`endif
    exp   = {4'b0000, pl};
    dword = 16'($urandom);
    dword[13:11] = addr;
    d0 = n_done; e0 = n_err; got = '0; extra_bad = 0;
    din  = dword[15];
    cs_n = 1'b0;
    #100;
    chk("oe_in_frame", dout_oe, 1);
    for (int i = 0; i < nrise; i++) begin
      if (i < 16) got[15-i] = dout;
      else if (dout !== 1'b0) extra_bad++;
      sclk = 1'b1;
      #80;
      sclk = 1'b0;
      if (scramble && i == 5) begin
        for (int k = 0; k < 8; k++) mem[k] = 12'($urandom);
        load_mem();
      end
      din = (i + 1 < 16) ? dword[14-i] : 1'($urandom);
      #80;
    end
    cs_n = 1'b1;
    #200;
    if (nrise >= 16) begin
      chk("payload", got, exp);
      chk("hold_dout_zero", extra_bad, 0);
      chk("done_pulse", n_done - d0, 1);
      chk("no_err", n_err - e0, 0);
      cur_m  = addr;
      fcnt_m = fcnt_m + 9'd1;
    end else begin
      chk("err_pulse", n_err - e0, 1);
      chk("no_done", n_done - d0, 0);
      if (nrise > 0) begin
        mask = ~(16'hFFFF >> nrise);
        chk("partial_bits", got & mask, exp & mask);
      end
    end
    chk("cur_chan", cur_chan, cur_m);
    chk("idle_oe", dout_oe, 0);
    chk("idle_dout", dout, 0);
  endtask

  initial begin
    int d0, e0;
    reset = 1'b1; sclk = 1'b0; cs_n = 1'b1; din = 1'b0;
    for (int k = 0; k < 8; k++) mem[k] = 12'h000;
    mem[0] = 12'hABC;
    load_mem();
    #23;
    chk("rst_dout", dout, 0);
    chk("rst_oe", dout_oe, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_cur_chan", cur_chan, 0);
    reset = 1'b0;
    #50;

    frame(3'b101, 16, 1'b0);
    chk("first_cur_chan", cur_chan, 3'd5);
    mem[5] = 12'h123;
    load_mem();
    frame(3'b010, 16, 1'b0);
    chk("second_cur_chan", cur_chan, 3'd2);
    frame(3'b111, 9, 1'b0);
    frame(3'b110, 20, 1'b0);

    // reset in the middle of a frame
    for (int k = 0; k < 8; k++) mem[k] = 12'($urandom);
    load_mem();
    d0 = n_done; e0 = n_err;
    cs_n = 1'b0;
    #100;
    for (int i = 0; i < 7; i++) begin
      sclk = 1'b1; #80; sclk = 1'b0; #80;
    end
    reset = 1'b1;
    #30;
    chk("midrst_dout", dout, 0);
    chk("midrst_oe", dout_oe, 0);
    cs_n = 1'b1;
    #50;
    reset = 1'b0;
    #200;
    chk("midrst_no_done", n_done - d0, 0);
    chk("midrst_no_err", n_err - e0, 0);
    chk("midrst_cur_chan", cur_chan, 0);
    cur_m = 3'd0; fcnt_m = 9'd0;
    frame(3'($urandom), 16, 1'b0);

    // boundary counts around the 16-edge frame, then random frames
    frame(3'($urandom), 15, 1'b0);
    frame(3'($urandom), 0, 1'b0);
    frame(3'($urandom), 16, 1'b1);
    for (int n = 0; n < 20; n++) begin
      for (int k = 0; k < 8; k++) mem[k] = 12'($urandom);
      load_mem();
      frame(3'($urandom), int'($urandom_range(0, 20)), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
